// File: rtl/cacheline_adaptor_if.sv
// Line-side (cache <-> adaptor) and memory-side (adaptor <-> DRAM pins) bundles.
// master drives the request, slave answers it.
interface cacheline_adaptor_line_if #(
  parameter int LINE_WIDTH = 256
);
  logic                  line_read_i;
  logic                  line_write_i;
  logic [31:0]           line_addr_i;
  logic [LINE_WIDTH-1:0] line_wdata_i;
  logic [LINE_WIDTH-1:0] line_rdata_o;
  logic                  line_resp_o;

  modport master (
    output line_read_i, line_write_i, line_addr_i, line_wdata_i,
    input  line_rdata_o, line_resp_o
  );

  modport slave (
    input  line_read_i, line_write_i, line_addr_i, line_wdata_i,
    output line_rdata_o, line_resp_o
  );
endinterface

interface cacheline_adaptor_mem_if #(
  parameter int BEAT_WIDTH = 64
);
  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [BEAT_WIDTH-1:0] mem_wdata;
  logic [BEAT_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts single 256-bit cache line reads/write-backs into 4-beat 64-bit
// memory bursts, one outstanding transaction at a time.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int BURST_LEN   = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  cacheline_adaptor_line_if.slave   line,
  cacheline_adaptor_mem_if.master   mem
);
  localparam int CNT_BITS = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t                state;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   next_cnt;
  logic                  last_beat;
  logic [LINE_WIDTH-1:0] wr_line;
  logic [LINE_WIDTH-1:0] rd_line;
  logic [31:0]           aligned_addr;
  logic                  unused_offset;

  assign aligned_addr  = {line.line_addr_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_offset = ^line.line_addr_i[OFFSET_BITS-1:0];
  assign next_cnt      = cnt + 1'b1;
  assign last_beat     = (cnt == CNT_BITS'(BURST_LEN - 1));

  // Fill data is staged in rd_line and only published on the last beat,
  // so line_rdata_o keeps the previous line for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      wr_line           <= '0;
      rd_line           <= '0;
      mem.mem_read      <= 1'b0;
      mem.mem_write     <= 1'b0;
      mem.mem_address   <= '0;
      mem.mem_wdata     <= '0;
      line.line_rdata_o <= '0;
      line.line_resp_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (line.line_write_i) begin
            state           <= WR_BURST;
            mem.mem_address <= aligned_addr;
            wr_line         <= line.line_wdata_i;
            mem.mem_wdata   <= line.line_wdata_i[BEAT_WIDTH-1:0];
            mem.mem_write   <= 1'b1;
          end else if (line.line_read_i) begin
            state           <= RD_BURST;
            mem.mem_address <= aligned_addr;
            mem.mem_read    <= 1'b1;
          end
        end
        RD_BURST: begin
          if (mem.mem_resp) begin
            rd_line[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] <= mem.mem_rdata;
            cnt <= next_cnt;
            if (last_beat) begin
              state             <= DONE;
              mem.mem_read      <= 1'b0;
              line.line_resp_o  <= 1'b1;
              line.line_rdata_o <= {mem.mem_rdata, rd_line[LINE_WIDTH-BEAT_WIDTH-1:0]};
            end
          end
        end
        WR_BURST: begin
          if (mem.mem_resp) begin
            cnt           <= next_cnt;
            mem.mem_wdata <= wr_line[BEAT_WIDTH*int'(next_cnt) +: BEAT_WIDTH];
            if (last_beat) begin
              state            <= DONE;
              mem.mem_write    <= 1'b0;
              line.line_resp_o <= 1'b1;
            end
          end
        end
        DONE: begin
          line.line_resp_o <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench: table of line transactions against a beat-level memory
// model, with scoreboards for completed lines and expected write beats.
module tb_cacheline_adaptor;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cacheline_adaptor_line_if #(.LINE_WIDTH(256)) lif ();
  cacheline_adaptor_mem_if  #(.BEAT_WIDTH(64))  mif ();

  cacheline_adaptor dut (
    .clk  (clk),
    .rst  (rst),
    .line (lif),
    .mem  (mif)
  );

  typedef struct {
    bit               is_rd;
    bit               is_wr;
    logic [31:0]      addr;
    logic [31:0]      exp_addr;
    logic [255:0]     wdata;
    logic [3:0][63:0] beats;
    logic [3:0][3:0]  waits;
    logic [255:0]     exp_line;
  } vec_t;

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
  } resp_t;

  vec_t        vec [9];
  resp_t       rq [$];
  logic [63:0] wq [$];

  int checks = 0;
  int errors = 0;
  int resp_count = 0;

  logic [3:0][63:0] cur_beats;
  logic [3:0][3:0]  cur_waits;
  bit               cur_wr;
  logic [31:0]      exp_addr;
  bit               busy;
  int               beat;
  int               wait_left;
  int               stray_left;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] eaddr, input logic [255:0] wdata,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3);
    vec[i].is_rd    = rd;
    vec[i].is_wr    = wr;
    vec[i].addr     = addr;
    vec[i].exp_addr = eaddr;
    vec[i].wdata    = wdata;
    vec[i].beats    = {b3, b2, b1, b0};
    vec[i].waits    = {w3, w2, w1, w0};
    vec[i].exp_line = {b3, b2, b1, b0};
  endtask

  // Memory model plus completion monitor: first beat arrives one cycle after
  // the request appears, then each beat is preceded by its table wait count.
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      mif.mem_resp = 1'b0;
      busy = 1'b0;
    end else if (mif.mem_read || mif.mem_write) begin
      if (!busy) begin
        busy = 1'b1;
        beat = 0;
        wait_left = 1 + int'(cur_waits[0]);
      end
      check_output("mem_address", 256'(mif.mem_address), 256'(exp_addr));
      if (cur_wr) check_output("mem_read_in_write", 256'(mif.mem_read), 256'(0));
      if (beat >= 4) begin
        mif.mem_resp = 1'b0;
      end else if (wait_left > 0) begin
        mif.mem_resp = 1'b0;
        wait_left--;
        if (cur_wr && wq.size() > 0) check_output("mem_wdata_hold", 256'(mif.mem_wdata), 256'(wq[0]));
      end else begin
        mif.mem_resp = 1'b1;
        if (cur_wr) begin
          if (wq.size() > 0) begin
            check_output("mem_wdata", 256'(mif.mem_wdata), 256'(wq.pop_front()));
          end else begin
            checks++;
            errors++;
            $display("[TB] FAIL extra_write_beat: got %h expected none", mif.mem_wdata);
          end
        end else begin
          mif.mem_rdata = cur_beats[beat];
        end
        beat++;
        if (beat < 4) wait_left = int'(cur_waits[beat]);
      end
    end else begin
      busy = 1'b0;
      mif.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (stray_left > 0) begin
        mif.mem_resp = 1'b1;
        stray_left--;
      end else begin
        mif.mem_resp = 1'b0;
      end
    end

    if (rst && lif.line_resp_o) begin
      resp_count++;
      check_output("done_mem_idle", 256'({mif.mem_read, mif.mem_write}), 256'(0));
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got line_resp_o=1 expected 0");
      end else begin
        r = rq.pop_front();
        check_output(r.is_rd ? "read_line" : "write_keeps_line", lif.line_rdata_o, r.line);
      end
    end
  end

  // Presents a table transaction; caller is positioned just after a rising edge.
  task automatic apply_stimulus(input int i);
    exp_addr  = vec[i].exp_addr;
    cur_beats = vec[i].beats;
    cur_waits = vec[i].waits;
    cur_wr    = vec[i].is_wr;
    if (vec[i].is_wr) begin
      for (int k = 0; k < 4; k++) wq.push_back(vec[i].beats[k]);
      rq.push_back('{is_rd: 1'b0, line: vec[i].exp_line});
    end else begin
      rq.push_back('{is_rd: 1'b1, line: vec[i].exp_line});
    end
    lif.line_read_i  = vec[i].is_rd;
    lif.line_write_i = vec[i].is_wr;
    lif.line_addr_i  = vec[i].addr;
    lif.line_wdata_i = vec[i].wdata;
  endtask

  // Waits for line_resp_o, checks its latency, drops the request on the edge ending DONE.
  task automatic await_resp(input int i);
    int n = 0;
    bit seen = 1'b0;
    int lat = 6;
    for (int k = 0; k < 4; k++) lat += int'(vec[i].waits[k]);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lif.line_resp_o) begin
        seen = 1'b1;
        n = c;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout: got no line_resp_o for vector %0d expected one within 100 cycles", i);
      rq.delete();
      wq.delete();
    end else begin
      check_output("resp_latency", 256'(n), 256'(lat));
    end
    @(posedge clk);
    #1;
    lif.line_read_i  = 1'b0;
    lif.line_write_i = 1'b0;
    check_output("resp_one_cycle", 256'(lif.line_resp_o), 256'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_mem_read"},    256'(mif.mem_read),    256'(0));
    check_output({tag, "_mem_write"},   256'(mif.mem_write),   256'(0));
    check_output({tag, "_mem_address"}, 256'(mif.mem_address), 256'(0));
    check_output({tag, "_mem_wdata"},   256'(mif.mem_wdata),   256'(0));
    check_output({tag, "_line_rdata"},  lif.line_rdata_o,      256'(0));
    check_output({tag, "_line_resp"},   256'(lif.line_resp_o), 256'(0));
  endtask

  initial begin
    int base;
    bit reached;
    rst = 1'b0;
    lif.line_read_i  = 1'b0;
    lif.line_write_i = 1'b0;
    lif.line_addr_i  = '0;
    lif.line_wdata_i = '0;
    mif.mem_resp     = 1'b0;
    mif.mem_rdata    = '0;
    stray_left = 0;
    cur_beats  = '0;
    cur_waits  = '0;
    cur_wr     = 1'b0;
    exp_addr   = '0;
    busy       = 1'b0;
    beat       = 0;
    wait_left  = 0;

    set_vec(0, 1, 0, 32'h0000_1234, 32'h0000_1220, '0,
            64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 0, 0);
    set_vec(1, 0, 1, 32'h0000_ABCD, 32'h0000_ABC0,
            {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
            64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
            64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 0, 0, 2, 0);
    set_vec(2, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
            {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
            64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
            64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 0, 1, 0, 0);
    set_vec(3, 1, 0, 32'h8000_0041, 32'h8000_0040, '0,
            64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0002,
            64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0004, 0, 1, 0, 3);
    set_vec(4, 1, 0, 32'h0000_0100, 32'h0000_0100, '0,
            64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
            64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, 0, 0, 0, 0);
    set_vec(5, 1, 0, 32'h2000_001F, 32'h2000_0000, '0,
            64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
            64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 0, 0, 0, 0);
    set_vec(6, 1, 0, 32'h3000_0067, 32'h3000_0060, '0,
            64'h9999_0000_9999_0000, 64'h0000_9999_0000_9999,
            64'h1234_5678_1234_5678, 64'h8765_4321_8765_4321, 0, 0, 1, 0);
    set_vec(7, 0, 1, 32'h4000_0080, 32'h4000_0080,
            {64'h7070_7070_7070_7070, 64'h6060_6060_6060_6060,
             64'h5050_5050_5050_5050, 64'h4040_4040_4040_4040},
            64'h4040_4040_4040_4040, 64'h5050_5050_5050_5050,
            64'h6060_6060_6060_6060, 64'h7070_7070_7070_7070, 0, 0, 0, 0);
    set_vec(8, 1, 0, 32'h5000_00A3, 32'h5000_00A0, '0,
            64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
            64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4, 0, 0, 0, 0);
    vec[1].exp_line = vec[0].exp_line;
    vec[2].exp_line = vec[0].exp_line;
    vec[7].exp_line = vec[6].exp_line;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(i);
      await_resp(i);
    end

    // Stray memory strobes while idle must not count toward the next read.
    base = resp_count;
    stray_left = 3;
    repeat (4) @(posedge clk);
    #1;
    check_output("stray_no_resp", 256'(resp_count), 256'(base));
    apply_stimulus(4);
    await_resp(4);

    // Reset after the second beat of a read abandons it silently.
    apply_stimulus(5);
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (busy && beat == 2) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      checks++;
      errors++;
      $display("[TB] FAIL reset_setup: got beat=%0d expected 2 within 50 cycles", beat);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    lif.line_read_i = 1'b0;
    #1;
    check_all_zero("midreset");
    rq.delete();
    wq.delete();
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(6);
    await_resp(6);

    // Write then a read issued in the cycle right after DONE.
    base = resp_count;
    apply_stimulus(7);
    await_resp(7);
    apply_stimulus(8);
    await_resp(8);
    repeat (3) @(posedge clk);
    #1;
    check_output("back_to_back_pulses", 256'(resp_count - base), 256'(2));
    check_output("scoreboard_drained", 256'(rq.size() + wq.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
